// File: rtl/period_gen_pkg.sv
// Shared definitions for the burst square-wave generator: default widths and
// the 2-bit state encodings.
package period_gen_pkg;

  localparam int unsigned CNT_WIDTH_DEF   = 32;
  localparam int unsigned BURST_WIDTH_DEF = 10;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_HIGH = 2'd1;
  localparam logic [1:0] ENC_LOW  = 2'd2;
  localparam logic [1:0] ENC_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ENC_IDLE,
    S_HIGH = ENC_HIGH,
    S_LOW  = ENC_LOW,
    S_DONE = ENC_DONE
  } state_e;

endpackage

// File: rtl/period_gen.sv
// Burst square-wave generator: H cycles high, P-H low, repeated n times
// (n=0 runs until stop). Configuration is latched when a burst starts.
module period_gen
  import period_gen_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int unsigned BURST_WIDTH = BURST_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [CNT_WIDTH-1:0]   period_cycles,
  input  logic [CNT_WIDTH-1:0]   high_cycles,
  input  logic [BURST_WIDTH-1:0] n_cycles,
  output logic                   sig_out,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  state_e                 state_q, state_d;
  logic                   sig_q, sig_d;
  logic                   cfg_err_q, cfg_err_d;
  logic [CNT_WIDTH-1:0]   ph_cnt_q, ph_cnt_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic [CNT_WIDTH-1:0]   hi_q, hi_d;
  logic [CNT_WIDTH-1:0]   lo_q, lo_d;
  logic [BURST_WIDTH-1:0] n_q, n_d;
  logic                   cfg_ok;

  assign cfg_ok = (period_cycles >= CNT_WIDTH'(2)) && (high_cycles != '0) &&
                  (high_cycles < period_cycles);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      sig_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      ph_cnt_q  <= '0;
      burst_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      n_q       <= '0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      cfg_err_q <= cfg_err_d;
      ph_cnt_q  <= ph_cnt_d;
      burst_q   <= burst_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      n_q       <= n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sig_d     = 1'b0;
    cfg_err_d = 1'b0;
    ph_cnt_d  = ph_cnt_q;
    burst_d   = burst_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    n_d       = n_q;
    unique case (state_q)
      S_IDLE: begin
        // stop outranks start, so a start raised together with stop is dropped
        if (start && !stop) begin
          if (cfg_ok) begin
            hi_d     = high_cycles;
            lo_d     = period_cycles - high_cycles;
            n_d      = n_cycles;
            ph_cnt_d = CNT_WIDTH'(1);
            burst_d  = BURST_WIDTH'(1);
            sig_d    = 1'b1;
            state_d  = S_HIGH;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_HIGH: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (ph_cnt_q == hi_q) begin
          ph_cnt_d = CNT_WIDTH'(1);
          state_d  = S_LOW;
        end else begin
          ph_cnt_d = ph_cnt_q + CNT_WIDTH'(1);
          sig_d    = 1'b1;
        end
      end
      S_LOW: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (ph_cnt_q == lo_q) begin
          if ((n_q != '0) && (burst_q == n_q)) begin
            state_d = S_DONE;
          end else begin
            // burst_q counts rising edges; it holds at all-ones in continuous mode
            if (burst_q != '1) burst_d = burst_q + BURST_WIDTH'(1);
            ph_cnt_d = CNT_WIDTH'(1);
            sig_d    = 1'b1;
            state_d  = S_HIGH;
          end
        end else begin
          ph_cnt_d = ph_cnt_q + CNT_WIDTH'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sig_out = sig_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_period_gen.sv
// Self-checking bench for period_gen; expected outputs come from a
// cycle-index model: during a burst, sig = (k mod P) < H.
module tb_period_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic [31:0] period_cycles;
  logic [31:0] high_cycles;
  logic [9:0]  n_cycles;
  logic        sig_out;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int errors = 0;
  int checks = 0;

  // model: 0 idle, 1 running (k = cycles since burst began), 2 done cycle
  int m_st = 0;
  int m_k  = 0;
  int m_P  = 0;
  int m_H  = 0;
  int m_N  = 0;
  bit m_cfg = 1'b0;

  period_gen #(.CNT_WIDTH(32), .BURST_WIDTH(10)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .period_cycles(period_cycles), .high_cycles(high_cycles), .n_cycles(n_cycles),
    .sig_out(sig_out), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] exp_vec();
    logic s;
    s = (m_st == 1) && ((m_k % m_P) < m_H);
    return {s, m_st != 0, m_st == 2, m_cfg};
  endfunction

  task automatic model_update(input bit st, input bit sp, input int P, input int H, input int N);
    m_cfg = 1'b0;
    case (m_st)
      1: begin
        if (sp) m_st = 0;
        else begin
          m_k++;
          if (m_N != 0 && m_k == m_N * m_P) m_st = 2;
        end
      end
      2: m_st = 0;
      default: begin
        if (st && !sp) begin
          if (P >= 2 && H >= 1 && H < P) begin
            m_st = 1; m_k = 0; m_P = P; m_H = H; m_N = N;
          end else m_cfg = 1'b1;
        end
      end
    endcase
  endtask

  // Drive one cycle of inputs, advance past the edge, update the model.
  task automatic tick(input bit st, input bit sp, input int P, input int H, input int N);
    start = st; stop = sp;
    period_cycles = P; high_cycles = H; n_cycles = N[9:0];
    @(posedge clk);
    model_update(st, sp, P, H, N);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    period_cycles = '0; high_cycles = '0; n_cycles = '0;
    #1;
    checks++;
    if ({sig_out, busy, done, cfg_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_async got=%b exp=0000", {sig_out, busy, done, cfg_err});
    end
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 10, 4, 3);
      checks++;
      if ({sig_out, busy, done, cfg_err} !== exp_vec()) begin
        errors++; $display("FAIL reset_idle got=%b exp=%b", {sig_out, busy, done, cfg_err}, exp_vec());
      end
    end
  endtask

  task automatic test_basic();
    int edges[$];
    int done_at = -1;
    int busy_n = 0;
    logic prev = 1'b0;
    tick(1'b1, 1'b0, 10, 4, 3);
    for (int c = 1; c <= 33; c++) begin
      checks++;
      if ({sig_out, busy, done, cfg_err} !== exp_vec()) begin
        errors++; $display("FAIL basic cyc=%0d got=%b exp=%b", c, {sig_out, busy, done, cfg_err}, exp_vec());
      end
      if (sig_out && !prev) edges.push_back(c);
      if (done) done_at = c;
      if (busy) busy_n++;
      prev = sig_out;
      tick(1'b0, 1'b0, 3, 1, 7);
    end
    checks++;
    if (edges.size() != 3 || edges[0] != 1 || edges[1] != 11 || edges[2] != 21) begin
      errors++; $display("FAIL basic_edges got=%p exp='{1,11,21}", edges);
    end
    checks++;
    if (done_at != 31) begin
      errors++; $display("FAIL basic_done_at got=%0d exp=31", done_at);
    end
    checks++;
    if (busy_n != 31) begin
      errors++; $display("FAIL basic_busy_len got=%0d exp=31", busy_n);
    end
  endtask

  task automatic test_cfg_reject();
    int cfgs[3][2] = '{'{10, 10}, '{1, 0}, '{10, 0}};
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, cfgs[i][0], cfgs[i][1], 2);
      checks++;
      if ({sig_out, busy, done, cfg_err} !== 4'b0001 || exp_vec() !== 4'b0001) begin
        errors++; $display("FAIL cfg_reject%0d got=%b exp=0001", i, {sig_out, busy, done, cfg_err});
      end
      tick(1'b0, 1'b0, cfgs[i][0], cfgs[i][1], 2);
      checks++;
      if ({sig_out, busy, done, cfg_err} !== exp_vec()) begin
        errors++; $display("FAIL cfg_after%0d got=%b exp=%b", i, {sig_out, busy, done, cfg_err}, exp_vec());
      end
    end
  endtask

  task automatic test_min_period();
    int done_at = -1;
    tick(1'b1, 1'b0, 2, 1, 4);
    for (int c = 1; c <= 10; c++) begin
      checks++;
      if ({sig_out, busy, done, cfg_err} !== exp_vec()) begin
        errors++; $display("FAIL minp cyc=%0d got=%b exp=%b", c, {sig_out, busy, done, cfg_err}, exp_vec());
      end
      if (c <= 8) begin
        checks++;
        if (sig_out !== logic'(c % 2)) begin
          errors++; $display("FAIL minp_toggle cyc=%0d got=%b exp=%0d", c, sig_out, c % 2);
        end
      end
      if (done) done_at = c;
      tick(1'b0, 1'b0, 2, 1, 4);
    end
    checks++;
    if (done_at != 9) begin
      errors++; $display("FAIL minp_done_at got=%0d exp=9", done_at);
    end
  endtask

  task automatic test_continuous_stop();
    int done_seen = 0;
    tick(1'b1, 1'b0, 6, 3, 0);
    for (int c = 1; c <= 20; c++) begin
      checks++;
      if ({sig_out, busy, done, cfg_err} !== exp_vec()) begin
        errors++; $display("FAIL cont cyc=%0d got=%b exp=%b", c, {sig_out, busy, done, cfg_err}, exp_vec());
      end
      if (done) done_seen++;
      if (c < 20) tick(1'b0, 1'b0, 6, 3, 0);
    end
    tick(1'b0, 1'b1, 6, 3, 0);
    checks++;
    if ({sig_out, busy, done, cfg_err} !== 4'b0000 || done_seen != 0) begin
      errors++; $display("FAIL cont_stop got=%b done_seen=%0d exp=0000 done_seen=0", {sig_out, busy, done, cfg_err}, done_seen);
    end
    tick(1'b1, 1'b0, 6, 3, 0);
    checks++;
    if ({sig_out, busy, done, cfg_err} !== 4'b1100) begin
      errors++; $display("FAIL cont_restart got=%b exp=1100", {sig_out, busy, done, cfg_err});
    end
    tick(1'b0, 1'b1, 6, 3, 0);
    checks++;
    if ({sig_out, busy, done, cfg_err} !== exp_vec()) begin
      errors++; $display("FAIL cont_stop2 got=%b exp=%b", {sig_out, busy, done, cfg_err}, exp_vec());
    end
  endtask

  task automatic test_reset_midburst();
    int edges[$];
    int done_at = -1;
    logic prev = 1'b0;
    tick(1'b1, 1'b0, 10, 4, 0);
    tick(1'b0, 1'b0, 10, 4, 0);
    #3 reset = 1'b0;
    #1;
    m_st = 0; m_cfg = 1'b0;
    checks++;
    if ({sig_out, busy, done, cfg_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_mid got=%b exp=0000", {sig_out, busy, done, cfg_err});
    end
    @(posedge clk);
    #2 reset = 1'b1;
    tick(1'b0, 1'b0, 10, 4, 0);
    checks++;
    if ({sig_out, busy, done, cfg_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_wait got=%b exp=0000", {sig_out, busy, done, cfg_err});
    end
    tick(1'b1, 1'b0, 8, 3, 3);
    for (int c = 1; c <= 27; c++) begin
      checks++;
      if ({sig_out, busy, done, cfg_err} !== exp_vec()) begin
        errors++; $display("FAIL busy_start cyc=%0d got=%b exp=%b", c, {sig_out, busy, done, cfg_err}, exp_vec());
      end
      if (sig_out && !prev) edges.push_back(c);
      if (done) done_at = c;
      prev = sig_out;
      if (c >= 4 && c <= 7) tick(1'b1, 1'b0, 5, 2, 1);
      else tick(1'b0, 1'b0, 5, 2, 1);
    end
    checks++;
    if (edges.size() != 3 || edges[1] - edges[0] != 8 || edges[2] - edges[1] != 8 || done_at != 25) begin
      errors++; $display("FAIL busy_start_edges got=%p done_at=%0d exp='{1,9,17} done_at=25", edges, done_at);
    end
  endtask

  task automatic test_random();
    int P, H, N, lim;
    for (int b = 0; b < 30; b++) begin
      if ($urandom_range(0, 4) == 0) begin
        P = $urandom_range(0, 3); H = $urandom_range(0, 4);
      end else begin
        P = $urandom_range(2, 12); H = $urandom_range(1, P - 1);
      end
      N = $urandom_range(0, 3);
      lim = $urandom_range(3, 40);
      tick(1'b1, 1'b0, P, H, N);
      checks++;
      if ({sig_out, busy, done, cfg_err} !== exp_vec()) begin
        errors++; $display("FAIL rand b=%0d start got=%b exp=%b", b, {sig_out, busy, done, cfg_err}, exp_vec());
      end
      for (int c = 0; c < 200 && m_st != 0; c++) begin
        tick(1'($urandom_range(0, 1)), (N == 0 && c == lim) || ($urandom_range(0, 39) == 0),
             $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 5));
        checks++;
        if ({sig_out, busy, done, cfg_err} !== exp_vec()) begin
          errors++; $display("FAIL rand b=%0d c=%0d P=%0d H=%0d N=%0d got=%b exp=%b",
                             b, c, P, H, N, {sig_out, busy, done, cfg_err}, exp_vec());
        end
      end
      tick(1'b0, 1'b0, P, H, N);
      checks++;
      if ({sig_out, busy, done, cfg_err} !== exp_vec()) begin
        errors++; $display("FAIL rand b=%0d end got=%b exp=%b", b, {sig_out, busy, done, cfg_err}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cfg_reject();
    test_min_period();
    test_continuous_stop();
    test_reset_midburst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/period_gen.md
PERIOD_GEN -- requirements
Module: period_gen

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32: width of the period and high-time counters.
REQ-002 SHALL have parameter BURST_WIDTH, default 10: width of the burst-count input and counter.
REQ-003 SHALL have port clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: request to begin a burst; sampled only in S_IDLE.
REQ-006 SHALL have port stop, input, 1: abort the running burst.
REQ-007 SHALL have port period_cycles, input, CNT_WIDTH: output period in clk cycles.
REQ-008 SHALL have port high_cycles, input, CNT_WIDTH: high time per period in clk cycles.
REQ-009 SHALL have port n_cycles, input, BURST_WIDTH: periods per burst; 0 means continuous.
REQ-010 SHALL have port sig_out, output, 1: generated square wave, registered.
REQ-011 SHALL have port busy, output, 1: high whenever the state is not S_IDLE.
REQ-012 SHALL have port done, output, 1: one-cycle pulse when a finite burst completes.
REQ-013 SHALL have port cfg_err, output, 1: one-cycle pulse when a start is rejected.

Function
REQ-014 SHALL implement the states S_IDLE, S_HIGH, S_LOW and S_DONE.
REQ-015 SHALL, in S_IDLE, treat start as valid when period_cycles>=2, high_cycles>=1, high_cycles<period_cycles and stop=0.
REQ-016 SHALL, for a valid start sampled at cycle t, latch period_cycles, high_cycles and n_cycles, and enter S_HIGH at t+1.
REQ-017 SHALL, for an invalid start at cycle t, pulse cfg_err at t+1, remain in S_IDLE and leave sig_out low.
REQ-018 SHALL drive sig_out high for exactly H cycles, then low for P-H cycles, per period (P and H are the latched period and high values).
REQ-019 SHALL begin each following period's high phase immediately after the previous low phase, with no idle gap.
REQ-020 SHALL, for a latched n>0, produce exactly n rising edges, then enter S_DONE, so that done=1 and sig_out=0 at t+n*P+1.
REQ-021 SHALL leave S_DONE for S_IDLE on the next cycle; busy is high from t+1 through the S_DONE cycle inclusive.
REQ-022 SHALL, for a latched n=0, repeat periods indefinitely until stop is asserted.
REQ-023 SHALL, on stop in S_HIGH or S_LOW, enter S_IDLE on the next cycle with sig_out=0 and no done pulse.
REQ-024 SHALL give stop priority over start in the same cycle.
REQ-025 SHALL ignore start while busy, and SHALL NOT act on input changes while busy (the latched copies are used).
REQ-026 SHALL use phase counters that count 1 to H and 1 to P-H; the burst counter SHALL saturate and never wrap during a finite burst.
REQ-027 SHALL support the minimum configuration P=2, H=1, which toggles sig_out every cycle.

Reset
REQ-028 SHALL, while reset=0, immediately force the state to S_IDLE, sig_out=0, busy=0, done=0, cfg_err=0, and clear all counters and latched registers.
REQ-029 SHALL, on a reset asserted mid-burst, abort without a done pulse; after release the block SHALL wait in S_IDLE for a new start.

Structure
REQ-030 SHALL place the state encodings (2-bit localparams) and the default widths in the shared package.
REQ-031 SHALL be a single module with no sub-module; the phase counter and burst counter are inline.

Verification
REQ-032 SHALL verify a basic burst: P=10, H=4, n=3, start at t -> sig_out high t+1..t+4, low t+5..t+10; three rising edges at t+1, t+11, t+21; done at t+31; busy t+1..t+31.
REQ-033 SHALL verify configuration rejection: H=10, P=10 start at t -> cfg_err at t+1, busy stays 0, sig_out stays 0; likewise P=1 and H=0.
REQ-034 SHALL verify the minimum period: P=2, H=1, n=4 -> sig_out alternates 1,0 for 8 cycles from t+1, with done at t+9.
REQ-035 SHALL verify continuous mode and stop: n=0, P=6, H=3; stop at the 20th busy cycle -> idle next cycle, sig_out=0, no done pulse, start again accepted.
REQ-036 SHALL verify reset and start-while-busy: reset pulled low mid-high-phase -> all outputs 0 immediately; after release, a start with new P=8 yields edges 8 cycles apart, and a start issued while busy changes nothing.
